// File: rtl/i2c_write_sequencer.sv
// rtl/i2c_write_sequencer.sv - Table-driven register-write sequencer for I2C_master; optional ready timeout under `I2C_SEQ_TIMEOUT_EN
module i2c_write_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h68,
    parameter int         NUM_WRITES = 4,
    parameter int         GAP_CYCLES = 16
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    parameter int         TIMEOUT    = 4096
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       ready,
    output logic       start,
    output logic [6:0] addr,
    output logic [7:0] sub,
    output logic [7:0] data,
    output logic [3:0] idx,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_ARM       = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_WRITES - 1);
    localparam logic [12:0] GAP_LAST = 13'(GAP_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [3:0]  r_idx;
    logic [7:0]  r_sub;
    logic [7:0]  r_data;
    logic [6:0]  r_addr;
    logic        r_start;
    logic        r_done;
    logic [12:0] r_cnt;
    logic        w_restart;

    // Device-init table, {sub, data}; unused slots read as zero
    function automatic logic [15:0] rom_entry(input logic [3:0] i);
        case (i)
            4'd0:    rom_entry = 16'h200F;
            4'd1:    rom_entry = 16'h2330;
            4'd2:    rom_entry = 16'h2208;
            4'd3:    rom_entry = 16'h2400;
            default: rom_entry = 16'h0000;
        endcase
    endfunction

    // go only counts in the resting states; while a sequence runs it is ignored
    assign w_restart = go && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [12:0] TMO_LAST = 13'(TIMEOUT - 1);
    logic w_waiting;
    logic r_error;
    assign w_waiting = (r_state == S_ARM) || (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
`endif

    // Next-state decode; a stalled handshake state escalates to ERROR when the timeout is built in
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (go) w_state_next = S_LOAD;
            S_LOAD:      w_state_next = S_ARM;
            S_ARM:       if (r_start) w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!ready) w_state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (ready) w_state_next = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
            S_GAP:       if (r_cnt == GAP_LAST) w_state_next = S_LOAD;
            default:     w_state_next = S_IDLE;
        endcase
`ifdef I2C_SEQ_TIMEOUT_EN
        if (w_waiting && (r_cnt == TMO_LAST) && (w_state_next == r_state))
            w_state_next = S_ERROR;
`endif
    end

    // State, entry index, latched command fields and the one-cycle start pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_sub   <= 8'h20;
            r_data  <= 8'h0F;
            r_addr  <= DEV_ADDR;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= 13'd0;
        end else begin
            r_state <= w_state_next;
            // start is only ever high during a cycle spent in ARM; leaving ARM clears it
            r_start <= (w_state_next == S_ARM) && ready;
            // shared counter: gap length, and wait time when the timeout is built in
            r_cnt   <= (w_state_next == r_state) ? r_cnt + 13'd1 : 13'd0;
            if (w_restart) begin
                r_idx  <= 4'd0;
                r_done <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                {r_sub, r_data} <= rom_entry(r_idx);
                r_addr          <= DEV_ADDR;
            end
            if ((r_state == S_WAIT_DONE) && (w_state_next == S_GAP))
                r_idx <= r_idx + 4'd1;
            if ((r_state == S_WAIT_DONE) && (w_state_next == S_DONE))
                r_done <= 1'b1;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Sticky timeout flag, cleared only by the next accepted go or reset
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_error <= 1'b0;
        else if (w_restart)
            r_error <= 1'b0;
        else if ((w_state_next == S_ERROR) && (r_state != S_ERROR))
            r_error <= 1'b1;
    end
    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign start = r_start;
    assign addr  = r_addr;
    assign sub   = r_sub;
    assign data  = r_data;
    assign idx   = r_idx;
    assign busy  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done  = r_done;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb/tb_i2c_write_sequencer.sv - Self-checking bench for i2c_write_sequencer with a reactive master model
`timescale 1ns/1ps
module tb_i2c_write_sequencer;

    localparam int         NUM_WRITES = 4;
    localparam int         GAP_CYCLES = 16;
    localparam int         TIMEOUT    = 4096;
    localparam logic [6:0] DEV_ADDR   = 7'h68;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       go      = 1'b0;
    logic       ready   = 1'b1;
    logic       start;
    logic [6:0] addr;
    logic [7:0] sub;
    logic [7:0] data;
    logic [3:0] idx;
    logic       busy;
    logic       done;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] ref_tab [4] = '{16'h200F, 16'h2330, 16'h2208, 16'h2400};

    int busy_left = 0;
    int last_rise = -1;
    bit stuck     = 1'b0;

    logic [15:0] log_sd[$];
    int          log_idx[$];
    logic [6:0]  log_addr[$];
    int          log_cyc[$];
    int          log_gap[$];
    logic        prev_start = 1'b0;

    i2c_write_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .go      (go),
        .ready   (ready),
        .start   (start),
        .addr    (addr),
        .sub     (sub),
        .data    (data),
        .idx     (idx),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ref_entry(input int i);
        return (i >= 0 && i < 4) ? ref_tab[i] : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Master model: drops ready for a random busy time after each start
    always @(negedge clk) begin
        if (stuck) begin
            ready = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                ready     = 1'b1;
                last_rise = cyc;
            end
        end else if (start) begin
            ready     = 1'b0;
            busy_left = $urandom_range(60, 20);
        end
    end

    // Start monitor: logs every launched write and its gap from the previous ready rise
    always @(negedge clk) begin
        if (start) begin
            chk("start_width", prev_start, 1'b0);
            log_sd.push_back({sub, data});
            log_idx.push_back(int'(idx));
            log_addr.push_back(addr);
            log_cyc.push_back(cyc);
            if (idx != 4'd0 && last_rise >= 0)
                log_gap.push_back(cyc - last_rise);
        end
        prev_start = start;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_seq(input int base, input int n);
        chk("start_count", log_sd.size() - base, n);
        for (int i = 0; i < n && base + i < log_sd.size(); i++) begin
            chk("sub_data", log_sd[base + i], ref_entry(i));
            chk("entry_idx", log_idx[base + i], i);
            chk("entry_addr", log_addr[base + i], DEV_ADDR);
        end
    endtask

    initial begin
        int base;
        int gcyc;
        int k;
        int sc;

        // Reset state
        reset_n = 1'b0;
        tick(3);
        chk("rst_start", start, 1'b0);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_idx",   idx,   4'd0);
        chk("rst_sub",   sub,   8'h20);
        chk("rst_data",  data,  8'h0F);
        chk("rst_addr",  addr,  DEV_ADDR);
        reset_n = 1'b1;
        tick(2);

        // Full sequence, go -> first start latency
        base = log_sd.size();
        gcyc = cyc;
        pulse_go();
        wait_done("seq1_done", 3000);
        check_seq(base, NUM_WRITES);
        if (log_sd.size() > base) chk("go_to_start", log_cyc[base] - gcyc, 2);
        chk("seq1_busy", busy, 1'b0);
        chk("seq1_error", error, 1'b0);

        // Reset during WAIT_DONE of entry 2
        tick($urandom_range(20, 5));
        base = log_sd.size();
        pulse_go();
        k = 0;
        while (log_sd.size() < base + 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_entry2", log_sd.size() - base, 3);
        tick(5);
        chk("busy_pre_reset", busy, 1'b1);
        reset_n = 1'b0;
        tick(1);
        chk("abort_idx",   idx,   4'd0);
        chk("abort_busy",  busy,  1'b0);
        chk("abort_done",  done,  1'b0);
        chk("abort_start", start, 1'b0);
        tick(1);
        reset_n = 1'b1;
        tick(120);
        chk("no_start_after_reset", log_sd.size() - base, 3);
        base = log_sd.size();
        pulse_go();
        wait_done("replay_done", 3000);
        check_seq(base, NUM_WRITES);

        // go pulses while busy are ignored
        tick($urandom_range(10, 1));
        base = log_sd.size();
        pulse_go();
        k = 0;
        while (busy && k < 100) begin
            tick($urandom_range(15, 3));
            if (busy) pulse_go();
            k++;
        end
        wait_done("ignore_go_done", 3000);
        tick(30);
        check_seq(base, NUM_WRITES);

        // go after done clears done and replays
        base = log_sd.size();
        go = 1'b1;
        tick(1);
        go = 1'b0;
        chk("done_clear", done, 1'b0);
        chk("restart_busy", busy, 1'b1);
        wait_done("restart_done", 3000);
        check_seq(base, NUM_WRITES);

        // Gap after each ready rise
        chk("gaps_seen", log_gap.size() > 0, 1'b1);
        foreach (log_gap[i]) chk("gap_min", log_gap[i] >= GAP_CYCLES + 2, 1'b1);

        // ready stuck high after the first start
        tick(70);
        stuck = 1'b1;
        tick(2);
        base = log_sd.size();
        pulse_go();
        k = 0;
        while (log_sd.size() == base && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("stuck_first_start", log_sd.size() - base, 1);
        sc = (log_sd.size() > base) ? log_cyc[base] : cyc;
`ifdef I2C_SEQ_TIMEOUT_EN
        k = 0;
        while (!error && k < TIMEOUT + 200) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", cyc - sc, TIMEOUT + 1);
        chk("timeout_error", error, 1'b1);
        chk("timeout_idx", idx, 4'd0);
        chk("timeout_busy", busy, 1'b0);
        tick(200);
        chk("timeout_no_start", log_sd.size() - base, 1);
        stuck = 1'b0;
        pulse_go();
        chk("error_clear", error, 1'b0);
`else
        tick(10000);
        chk("stuck_busy", busy, 1'b1);
        chk("stuck_error", error, 1'b0);
        chk("stuck_no_start", log_sd.size() - base, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
